// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, funct codes,
// ALU operation encodings (also used by Data_Path's ALU) and FSM state encodings.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_IMMEXE = 4'd9;
  localparam logic [3:0] S_IMMWB  = 4'd10;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational R-type funct decoder: maps funct to an ALU operation and flags
// whether the funct is one the core implements.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       legal_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    legal_o  = 1'b1;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_NOR:  alu_op_o = ALU_NOR;
      FN_SLT:  alu_op_o = ALU_SLT;
      default: legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback, counts fetched instructions and flags illegal encodings.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode_i,
  input  logic [5:0]             funct_i,
  input  logic                   alu_zero_i,
  output logic                   enable_PC,
  output logic                   Selector_Addr,
  output logic                   enable_MemSys,
  output logic                   enable_RegIns,
  output logic                   enable_RF,
  output logic                   Selector_RF_WR,
  output logic                   Selector_RF_WD,
  output logic                   Selector_ALU_Src_A,
  output logic [1:0]             Selector_ALU_Src_B,
  output logic [2:0]             Selector_ALU_Op,
  output logic                   Selector_PC_Source,
  output logic [3:0]             state_o,
  output logic                   illegal_o,
  output logic [COUNT_WIDTH-1:0] instr_count_o
);

  logic [3:0]             state_q, state_d;
  logic                   illegal_q, illegal_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [2:0]             funct_op;
  logic                   funct_legal;

  alu_decoder u_alu_decoder (
    .funct_i  (funct_i),
    .alu_op_o (funct_op),
    .legal_o  (funct_legal)
  );

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    count_d   = count_q;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
        count_d = count_q + COUNT_WIDTH'(1);
      end
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_ADDI, OP_ORI:  state_d = S_IMMEXE;
          OP_RTYPE: begin
            if (funct_legal) state_d = S_EXEC;
            else             illegal_d = 1'b1;
          end
          default:          illegal_d = 1'b1;
        endcase
      end
      S_MEMADR: state_d = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_IMMEXE: state_d = S_IMMWB;
      // MEMWB, MEMWR, ALUWB, BRANCH, IMMWB and unused encodings all return to FETCH.
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    enable_PC          = 1'b0;
    Selector_Addr      = 1'b0;
    enable_MemSys      = 1'b0;
    enable_RegIns      = 1'b0;
    enable_RF          = 1'b0;
    Selector_RF_WR     = 1'b0;
    Selector_RF_WD     = 1'b0;
    Selector_ALU_Src_A = 1'b0;
    Selector_ALU_Src_B = 2'b00;
    Selector_ALU_Op    = ALU_ADD;
    Selector_PC_Source = 1'b0;
    case (state_q)
      S_FETCH: begin
        enable_RegIns      = 1'b1;
        Selector_ALU_Src_B = 2'b01;
        enable_PC          = 1'b1;
      end
      S_DECODE: Selector_ALU_Src_B = 2'b11;
      S_MEMADR: begin
        Selector_ALU_Src_A = 1'b1;
        Selector_ALU_Src_B = 2'b10;
      end
      S_MEMRD:  Selector_Addr = 1'b1;
      S_MEMWB: begin
        enable_RF      = 1'b1;
        Selector_RF_WD = 1'b1;
      end
      S_MEMWR: begin
        Selector_Addr = 1'b1;
        enable_MemSys = 1'b1;
      end
      S_EXEC: begin
        Selector_ALU_Src_A = 1'b1;
        Selector_ALU_Op    = funct_op;
      end
      S_ALUWB: begin
        enable_RF      = 1'b1;
        Selector_RF_WR = 1'b1;
      end
      S_BRANCH: begin
        Selector_ALU_Src_A = 1'b1;
        Selector_ALU_Op    = ALU_SUB;
        Selector_PC_Source = 1'b1;
        if (opcode_i == OP_BEQ)      enable_PC = alu_zero_i;
        else if (opcode_i == OP_BNE) enable_PC = ~alu_zero_i;
      end
      S_IMMEXE: begin
        Selector_ALU_Src_A = 1'b1;
        Selector_ALU_Src_B = 2'b10;
        Selector_ALU_Op    = (opcode_i == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IMMWB:  enable_RF = 1'b1;
      default: ;
    endcase
  end

  assign state_o       = state_q;
  assign illegal_o     = illegal_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (4-bit counter instance so the
// instruction count wrap is reachable in a short run).
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode_i = 6'b100011;
  logic [5:0] funct_i = 6'b000000;
  logic       alu_zero_i = 1'b0;
  logic       enable_PC, Selector_Addr, enable_MemSys, enable_RegIns, enable_RF;
  logic       Selector_RF_WR, Selector_RF_WD, Selector_ALU_Src_A, Selector_PC_Source;
  logic [1:0] Selector_ALU_Src_B;
  logic [2:0] Selector_ALU_Op;
  logic [3:0] state_o;
  logic       illegal_o;
  logic [3:0] instr_count_o;

  int errors = 0;
  int checks = 0;
  logic watch_rf = 1'b0;
  logic rf_pulsed = 1'b0;

  multicycle_control_unit #(.COUNT_WIDTH(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .opcode_i           (opcode_i),
    .funct_i            (funct_i),
    .alu_zero_i         (alu_zero_i),
    .enable_PC          (enable_PC),
    .Selector_Addr      (Selector_Addr),
    .enable_MemSys      (enable_MemSys),
    .enable_RegIns      (enable_RegIns),
    .enable_RF          (enable_RF),
    .Selector_RF_WR     (Selector_RF_WR),
    .Selector_RF_WD     (Selector_RF_WD),
    .Selector_ALU_Src_A (Selector_ALU_Src_A),
    .Selector_ALU_Src_B (Selector_ALU_Src_B),
    .Selector_ALU_Op    (Selector_ALU_Op),
    .Selector_PC_Source (Selector_PC_Source),
    .state_o            (state_o),
    .illegal_o          (illegal_o),
    .instr_count_o      (instr_count_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert (!(enable_RF && enable_MemSys)) else begin
        errors++;
        $error("FAIL rf_mem_excl observed rf=%0b mem=%0b expected not both 1", enable_RF, enable_MemSys);
      end
    end
    if (watch_rf && enable_RF) rf_pulsed = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // 1. reset, then lw
    opcode_i = 6'b100011;
    step();
    step();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_count", 32'(instr_count_o), 32'd0);
    check("rst_illegal", 32'(illegal_o), 32'd0);
    check("rst_regins", 32'(enable_RegIns), 32'd1);
    check("rst_pc_en", 32'(enable_PC), 32'd1);
    check("rst_srcb", 32'(Selector_ALU_Src_B), 32'd1);
    reset = 1'b0;
    step(); check("lw_decode", 32'(state_o), 32'd1);
    check("lw_count1", 32'(instr_count_o), 32'd1);
    check("decode_srcb", 32'(Selector_ALU_Src_B), 32'd3);
    check("decode_pc_en", 32'(enable_PC), 32'd0);
    step(); check("lw_memadr", 32'(state_o), 32'd2);
    check("memadr_src", 32'({Selector_ALU_Src_A, Selector_ALU_Src_B}), 32'b110);
    step(); check("lw_memrd", 32'(state_o), 32'd3);
    check("memrd_addr", 32'(Selector_Addr), 32'd1);
    step(); check("lw_memwb", 32'(state_o), 32'd4);
    check("memwb_ctl", 32'({enable_RF, Selector_RF_WD, Selector_RF_WR}), 32'b110);
    step(); check("lw_done", 32'(state_o), 32'd0);

    // 2. sw
    do_reset();
    opcode_i = 6'b101011;
    check("sw_fetch_mem", 32'(enable_MemSys), 32'd0);
    step(); check("sw_decode", 32'(state_o), 32'd1);
    check("sw_count1", 32'(instr_count_o), 32'd1);
    step(); check("sw_memadr", 32'(state_o), 32'd2);
    check("sw_memadr_mem", 32'(enable_MemSys), 32'd0);
    step(); check("sw_memwr", 32'(state_o), 32'd5);
    check("memwr_ctl", 32'({enable_MemSys, Selector_Addr, enable_RF}), 32'b110);
    step(); check("sw_done", 32'(state_o), 32'd0);
    check("sw_done_mem", 32'(enable_MemSys), 32'd0);

    // 3. beq / bne
    opcode_i = 6'b000100; alu_zero_i = 1'b1;
    step(); step();
    check("beq_branch", 32'(state_o), 32'd8);
    check("beq_taken", 32'({enable_PC, Selector_PC_Source}), 32'b11);
    check("beq_op", 32'(Selector_ALU_Op), 32'b001);
    alu_zero_i = 1'b0; #1;
    check("beq_not_taken", 32'(enable_PC), 32'd0);
    step(); check("beq_done", 32'(state_o), 32'd0);
    opcode_i = 6'b000101; alu_zero_i = 1'b1;
    step(); step();
    check("bne_branch", 32'(state_o), 32'd8);
    check("bne_zero_pc", 32'(enable_PC), 32'd0);
    alu_zero_i = 1'b0; #1;
    check("bne_nz_pc", 32'(enable_PC), 32'd1);
    step(); check("bne_done", 32'(state_o), 32'd0);
    check("count_after_3", 32'(instr_count_o), 32'd3);

    // 4. R-type slt, then illegal funct
    opcode_i = 6'b000000; funct_i = 6'b101010;
    step(); step();
    check("slt_exec", 32'(state_o), 32'd6);
    check("slt_op", 32'(Selector_ALU_Op), 32'b101);
    check("exec_src", 32'({Selector_ALU_Src_A, Selector_ALU_Src_B}), 32'b100);
    step(); check("slt_aluwb", 32'(state_o), 32'd7);
    check("aluwb_ctl", 32'({enable_RF, Selector_RF_WR, Selector_RF_WD}), 32'b110);
    step(); check("slt_done", 32'(state_o), 32'd0);
    check("illegal_clear", 32'(illegal_o), 32'd0);
    funct_i = 6'b000001;
    step(); step();
    check("bad_funct_fetch", 32'(state_o), 32'd0);
    check("bad_funct_flag", 32'(illegal_o), 32'd1);

    // addi / ori keep the sticky flag
    opcode_i = 6'b001000; funct_i = 6'b100000;
    step(); step();
    check("addi_immexe", 32'(state_o), 32'd9);
    check("addi_op", 32'(Selector_ALU_Op), 32'b000);
    check("immexe_src", 32'({Selector_ALU_Src_A, Selector_ALU_Src_B}), 32'b110);
    step(); check("addi_immwb", 32'(state_o), 32'd10);
    check("immwb_ctl", 32'({enable_RF, Selector_RF_WR, Selector_RF_WD}), 32'b100);
    step(); check("illegal_sticky", 32'(illegal_o), 32'd1);
    opcode_i = 6'b001101;
    step(); step();
    check("ori_op", 32'(Selector_ALU_Op), 32'b011);
    step(); step();
    opcode_i = 6'b111111;
    step(); step();
    check("bad_opcode_fetch", 32'(state_o), 32'd0);

    // 5. reset during MEMRD aborts the lw
    do_reset();
    opcode_i = 6'b100011;
    step(); step(); step();
    check("abort_memrd", 32'(state_o), 32'd3);
    watch_rf = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_count", 32'(instr_count_o), 32'd0);
    check("abort_illegal", 32'(illegal_o), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("abort_resume", 32'(state_o), 32'd1);
    watch_rf = 1'b0;
    check("abort_no_rf", 32'(rf_pulsed), 32'd0);

    // 6. 17 addi wraps the 4-bit count to 1
    do_reset();
    opcode_i = 6'b001000;
    for (int i = 0; i < 17 * 4; i++) step();
    check("wrap_state", 32'(state_o), 32'd0);
    check("wrap_count", 32'(instr_count_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
